// File: rtl/dec_1.sv
// dec_1: 10x6 fixed-point matrix-vector decode, y = sat((W*x + (b<<FRAC)) >>> FRAC), one MAC per cycle, done one cycle after edge T+70.
// No backpressure: start is only taken in IDLE, and w/b must be held steady while busy.
module dec_1 #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BITSIZE*60-1:0] w,
    input  logic [BITSIZE*6-1:0]  x,
    input  logic [BITSIZE*10-1:0] b,
    output logic [BITSIZE*10-1:0] y,
    output logic                  busy,
    output logic                  done
);
    localparam int ACCW = 2*BITSIZE + 4;
    localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               row_q, row_d;
    logic [2:0]               col_q, col_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic [BITSIZE*6-1:0]     x_q, x_d;
    logic [BITSIZE*10-1:0]    y_q, y_d;
    logic                     done_q, done_d;

    logic [6:0]                 w_idx;
    logic signed [BITSIZE-1:0]  w_sel, x_sel, b_sel;
    logic signed [2*BITSIZE-1:0] w_ext, x_ext, prod;
    logic signed [ACCW-1:0]     acc_add, bias_sh, row_sum, shifted;
    logic [BITSIZE-1:0]         res;

    assign w_idx = {3'b000, row_q} * 7'd6 + {4'b0000, col_q};
    assign w_sel = w[BITSIZE*w_idx +: BITSIZE];
    assign x_sel = x_q[BITSIZE*col_q +: BITSIZE];
    assign b_sel = b[BITSIZE*row_q +: BITSIZE];

    // Operands are sign-extended up front so the single multiplier yields the full signed product.
    assign w_ext   = {{BITSIZE{w_sel[BITSIZE-1]}}, w_sel};
    assign x_ext   = {{BITSIZE{x_sel[BITSIZE-1]}}, x_sel};
    assign prod    = w_ext * x_ext;
    assign acc_add = acc_q + {{(ACCW-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};

    assign bias_sh = {{(ACCW-BITSIZE){b_sel[BITSIZE-1]}}, b_sel} << FRAC;
    assign row_sum = acc_q + bias_sh;
    assign shifted = row_sum >>> FRAC;

    always_comb begin
        res = shifted[BITSIZE-1:0];
        if (shifted > SAT_MAX) begin
            res = SAT_MAX[BITSIZE-1:0];
        end else if (shifted < SAT_MIN) begin
            res = SAT_MIN[BITSIZE-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = x;
                    row_d   = '0;
                    col_d   = '0;
                    acc_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_add;
                if (col_q == 3'd5) begin
                    state_d = WRITE;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end
            WRITE: begin
                y_d[BITSIZE*row_q +: BITSIZE] = res;
                acc_d = '0;
                col_d = '0;
                if (row_q == 4'd9) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + 4'd1;
                    state_d = MAC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;
endmodule

// File: tb/tb_dec_1.sv
// Directed bench for dec_1: unity, bias, saturation, truncation, ignored start, abort and back-to-back runs.
module tb_dec_1;
    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [959:0]  w;
    logic [95:0]   x;
    logic [159:0]  b;
    logic [159:0]  y;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    dec_1 #(.BITSIZE(16), .FRAC(11)) dut (
        .clk(clk), .reset(reset), .start(start), .w(w), .x(x), .b(b),
        .y(y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [959:0] fill60(input logic [15:0] v);
        logic [959:0] r;
        for (int i = 0; i < 60; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [95:0] fill6(input logic [15:0] v);
        logic [95:0] r;
        for (int i = 0; i < 6; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    function automatic logic [159:0] fill10(input logic [15:0] v);
        logic [159:0] r;
        for (int i = 0; i < 10; i++) r[16*i +: 16] = v;
        return r;
    endfunction

    // Pulse start for one edge (edge T); returns in the cycle right after T.
    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in the cycle after T; returns in the done cycle (or after the cycle budget runs out).
    task automatic wait_done(input string tag, input logic [159:0] exp_y, input bit ign_pulse);
        int   lat    = -1;
        logic busy69 = 1'b0;
        chk({tag, "_busy_start"}, {159'b0, busy}, 160'd1);
        for (int i = 0; i < 100 && lat < 0; i++) begin
            if (ign_pulse && i == 19) start = 1'b1;
            if (ign_pulse && i == 20) start = 1'b0;
            if (i == 69) busy69 = busy;
            if (done) lat = i;
            else @(negedge clk);
        end
        chk({tag, "_latency"}, 160'(lat), 160'd70);
        chk({tag, "_busy_last"}, {159'b0, busy69}, 160'd1);
        chk({tag, "_busy_done"}, {159'b0, busy}, 160'd0);
        chk({tag, "_y"}, y, exp_y);
    endtask

    task automatic one_shot_done(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {159'b0, done}, 160'd0);
    endtask

    initial begin
        int   done_seen;
        logic [159:0] exp;

        reset = 1'b0;
        start = 1'b0;
        w = '0; x = '0; b = '0;
        #3;
        chk("rst_y", y, 160'd0);
        chk("rst_busy", {159'b0, busy}, 160'd0);
        chk("rst_done", {159'b0, done}, 160'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Unity: 6 * 1.0 * 1.0 = 6.0 = 0x3000
        w = fill60(16'h0800); x = fill6(16'h0800); b = fill10(16'h0000);
        kick();
        x = fill6(16'h1234);  // x may change after accept
        wait_done("unity", fill10(16'h3000), 1'b0);
        one_shot_done("unity");

        // Bias only
        w = fill60(16'h0000); x = fill6(16'h5A5A); b = fill10(16'h0400);
        kick();
        wait_done("bias", fill10(16'h0400), 1'b0);
        one_shot_done("bias");

        // Positive and negative saturation
        w = fill60(16'h7FFF); x = fill6(16'h7FFF); b = fill10(16'h0000);
        kick();
        wait_done("sat_pos", fill10(16'h7FFF), 1'b0);
        one_shot_done("sat_pos");

        w = fill60(16'h8000); x = fill6(16'h7FFF);
        kick();
        wait_done("sat_neg", fill10(16'h8000), 1'b0);
        one_shot_done("sat_neg");

        // Truncation toward minus infinity: -1/2048 * 0.5 -> -1 LSB
        w = '0; x = '0; b = '0;
        w[15:0] = 16'hFFFF; x[15:0] = 16'h0400;
        exp = '0; exp[15:0] = 16'hFFFF;
        kick();
        wait_done("trunc", exp, 1'b0);
        one_shot_done("trunc");

        // Start pulsed at T+20 must be ignored
        w = fill60(16'h0800); x = fill6(16'h0800); b = fill10(16'h0000);
        kick();
        wait_done("ignore", fill10(16'h3000), 1'b1);
        one_shot_done("ignore");

        // Abort near T+30, with start held during reset
        w = fill60(16'h0000); b = fill10(16'h0400);
        kick();
        repeat (29) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_y", y, 160'd0);
        chk("abort_busy", {159'b0, busy}, 160'd0);
        chk("abort_done", {159'b0, done}, 160'd0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("abort_busy_in_rst", {159'b0, busy}, 160'd0);
        reset = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_no_done", 160'(done_seen), 160'd0);
        chk("abort_y_after", y, 160'd0);
        chk("abort_idle", {159'b0, busy}, 160'd0);

        // Fresh unity run, then back-to-back start in the done cycle with a bias config
        w = fill60(16'h0800); x = fill6(16'h0800); b = fill10(16'h0000);
        kick();
        wait_done("post_abort", fill10(16'h3000), 1'b0);
        start = 1'b1;
        w = fill60(16'h0000); b = fill10(16'h0400);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_pulse", {159'b0, done}, 160'd0);
        wait_done("b2b", fill10(16'h0400), 1'b0);
        one_shot_done("b2b");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
